mc_cu: RTL
==========

# mc_cu

Multi-cycle control unit for the MIPS-subset datapath: sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and write-back states. It decodes the latched instruction's `op`/`func` and drives all datapath mux selects and write enables. It stalls on a memory ready handshake. It supports add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j and jal.

## Interface
- No parameters.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `op` in 6: opcode from instruction register.
- `func` in 6: function field from instruction register.
- `z` in 1: ALU zero flag, valid in EXE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `wpc` out 1: PC write enable.
- `wir` out 1: instruction register write enable.
- `wmem` out 1: memory write request.
- `wreg` out 1: register file write enable.
- `iord` out 1: memory address select, 0 = PC, 1 = ALU-out register.
- `regrt` out 1: destination is rt, not rd.
- `m2reg` out 1: write-back data from memory data register.
- `jal` out 1: write PC to r31.
- `shift` out 1: ALU A operand is sa.
- `sext` out 1: sign-extend immediate.
- `alusrca` out 1: ALU A select, 0 = PC, 1 = register A.
- `alusrcb` out 2: ALU B select, 00 = reg B, 01 = 4, 10 = imm, 11 = imm<<2.
- `aluc` out 4: ALU op.
- `pcsource` out 2: next-PC select, 00 = ALU, 01 = ALU-out (branch target), 10 = jr, 11 = jump.
- `illegal` out 1: sticky illegal-instruction flag (see Configuration).
- `state` out 3: current state, for debug.

## Operation
- ALU encodings, with x = don't care:
  - add x000, sub x100, and x001, or x101, xor x010, lui x110
  - sll 0011, srl 0111, sra 1111
- IF:
  - `iord`=0, `alusrca`=0, `alusrcb`=01, add, `pcsource`=00.
  - `wir` = `wpc` = `mem_ready`.
  - Stay in IF while `!mem_ready`; otherwise go to ID.
- ID:
  - `alusrca`=0, `alusrcb`=11, add, `sext`=1. The branch target is latched into ALU-out.
  - j: `wpc`=1, `pcsource`=11, then IF.
  - jal: same as j, plus `wreg`=1 and `jal`=1, then IF.
  - jr: `wpc`=1, `pcsource`=10, then IF.
  - Any other legal instruction: go to EXE.
- EXE:
  - R-type: `alusrca`=1 (or `shift`=1 for shifts), `alusrcb`=00, decoded `aluc`, then WB.
  - addi/andi/ori/xori/lui: `alusrcb`=10, `sext` only for addi, then WB.
  - lw/sw: `alusrcb`=10, `sext`=1, add, then MEM.
  - beq/bne: `alusrca`=1, `alusrcb`=00, sub, `pcsource`=01.
    - beq: `wpc` = `z`. bne: `wpc` = `!z`.
    - Then IF.
- MEM:
  - `iord`=1.
  - sw: `wmem`=1 held until `mem_ready`, then IF.
  - lw: wait for `mem_ready`, then WB.
- WB:
  - `wreg`=1.
  - `m2reg`=1 for lw.
  - `regrt`=1 for all I-type.
  - Then IF.
- Write enables (`wpc`, `wir`, `wreg`, `wmem`) are decoded from the state register and inputs. All other outputs are don't-care outside the states listed.

## Timing
- Zero-wait-state cycle counts:
  - j/jal/jr: 2 cycles.
  - beq/bne: 3 cycles.
  - R/I-type ALU and sw: 4 cycles.
  - lw: 5 cycles.
- Each low cycle of `mem_ready` in IF or MEM adds one cycle.
- Reset:
  - `reset` high → state = IF immediately.
  - `wpc`, `wreg`, `wmem`, `wir` forced 0 while reset is high; `illegal` = 0.
  - Fetch starts on the first clock edge after deassertion.
- Reset mid-access abandons the access. `wmem` drops asynchronously.
- `mem_ready` is ignored in ID, EXE and WB.
- `op`/`func` must stay stable from ID onward. They change only on `wir`.

## Configuration
- `MC_CU_ILLEGAL_TRAP_EN` defined:
  - An unsupported op/func in ID goes to state TRAP.
  - TRAP: all write enables 0, `illegal`=1, stays there until reset.
- Undefined:
  - An unsupported instruction behaves as a NOP: ID → IF, no writes.
  - `illegal` is tied to 0 and the TRAP state is not present.

## Structure
- Package `mc_cu_pkg` holds:
  - State enum: IF=0, ID=1, EXE=2, MEM=3, WB=4, TRAP=5.
  - Opcode and func constants.
  - `aluc`, `alusrcb` and `pcsource` encodings.
- Sub-module `mc_cu_decode`: purely combinational op/func → one-hot instruction flags plus `legal`.
- `mc_cu` itself holds the state register and output logic.

## Test plan
- add, op=000000 func=100000, `mem_ready`=1: states IF,ID,EXE,WB; `aluc`=0000 in EXE; `wreg`=1 only in WB; back in IF at cycle 5.
- lw, op=100011, `mem_ready` low 2 cycles in MEM: MEM lasts 3 cycles with `iord`=1; WB has `m2reg`=1 and `regrt`=1; 7 cycles total.
- beq, op=000100: with `z`=1, `wpc`=1 and `pcsource`=01 in EXE. With `z`=0, `wpc`=0. bne, op=000101, gives the inverse.
- jal, op=000011: in ID, `wpc`=1, `pcsource`=11, `wreg`=1, `jal`=1; next state is IF.
- sw, op=101011: `wmem` is held through the MEM stall. Assert `reset` mid-MEM: `wmem` drops at once, state=IF.
- op=111111:
  - With `MC_CU_ILLEGAL_TRAP_EN`: state=TRAP, `illegal`=1, no write enable for 10 cycles.
  - Without it: ID → IF, `illegal`=0.

Source files
------------

// File: rtl/mc_cu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit.
// The TRAP state exists only when MC_CU_ILLEGAL_TRAP_EN is defined.
package mc_cu_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned ALUC_W  = 4;
  localparam int unsigned SRCB_W  = 2;
  localparam int unsigned PCS_W   = 2;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
`ifdef MC_CU_ILLEGAL_TRAP_EN
    , S_TRAP = 3'd5
`endif
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNC_W-1:0] FN_XOR = 6'b100110;
  localparam logic [FUNC_W-1:0] FN_SLL = 6'b000000;
  localparam logic [FUNC_W-1:0] FN_SRL = 6'b000010;
  localparam logic [FUNC_W-1:0] FN_SRA = 6'b000011;
  localparam logic [FUNC_W-1:0] FN_JR  = 6'b001000;

  localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0100;
  localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0001;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0010;
  localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0110;
  localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0011;
  localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;
  localparam logic [ALUC_W-1:0] ALUC_SRA = 4'b1111;

  localparam logic [SRCB_W-1:0] SRCB_REG  = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM  = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMM4 = 2'b11;

  localparam logic [PCS_W-1:0] PCS_ALU    = 2'b00;
  localparam logic [PCS_W-1:0] PCS_ALUOUT = 2'b01;
  localparam logic [PCS_W-1:0] PCS_JR     = 2'b10;
  localparam logic [PCS_W-1:0] PCS_JUMP   = 2'b11;

  typedef struct packed {
    logic i_add;
    logic i_sub;
    logic i_and;
    logic i_or;
    logic i_xor;
    logic i_sll;
    logic i_srl;
    logic i_sra;
    logic i_jr;
    logic i_addi;
    logic i_andi;
    logic i_ori;
    logic i_xori;
    logic i_lw;
    logic i_sw;
    logic i_beq;
    logic i_bne;
    logic i_lui;
    logic i_j;
    logic i_jal;
  } inst_t;

endpackage

// File: rtl/mc_cu_decode.sv
// Combinational op/func decode into one-hot instruction flags plus a legal flag.
module mc_cu_decode
  import mc_cu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  output inst_t             inst,
  output logic              legal
);

  logic rtype;

  always_comb begin
    inst  = '0;
    rtype = (op == OP_RTYPE);
    inst.i_add  = rtype && (func == FN_ADD);
    inst.i_sub  = rtype && (func == FN_SUB);
    inst.i_and  = rtype && (func == FN_AND);
    inst.i_or   = rtype && (func == FN_OR);
    inst.i_xor  = rtype && (func == FN_XOR);
    inst.i_sll  = rtype && (func == FN_SLL);
    inst.i_srl  = rtype && (func == FN_SRL);
    inst.i_sra  = rtype && (func == FN_SRA);
    inst.i_jr   = rtype && (func == FN_JR);
    inst.i_addi = (op == OP_ADDI);
    inst.i_andi = (op == OP_ANDI);
    inst.i_ori  = (op == OP_ORI);
    inst.i_xori = (op == OP_XORI);
    inst.i_lw   = (op == OP_LW);
    inst.i_sw   = (op == OP_SW);
    inst.i_beq  = (op == OP_BEQ);
    inst.i_bne  = (op == OP_BNE);
    inst.i_lui  = (op == OP_LUI);
    inst.i_j    = (op == OP_J);
    inst.i_jal  = (op == OP_JAL);
    legal       = |inst;
  end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB sequencer driving datapath selects.
// Define MC_CU_ILLEGAL_TRAP_EN to trap unsupported instructions in a TRAP state.
module mc_cu
  import mc_cu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  input  logic               z,
  input  logic               mem_ready,
  output logic               wpc,
  output logic               wir,
  output logic               wmem,
  output logic               wreg,
  output logic               iord,
  output logic               regrt,
  output logic               m2reg,
  output logic               jal,
  output logic               shift,
  output logic               sext,
  output logic               alusrca,
  output logic [SRCB_W-1:0]  alusrcb,
  output logic [ALUC_W-1:0]  aluc,
  output logic [PCS_W-1:0]   pcsource,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t              state_q, state_d;
  inst_t               inst;
  logic                legal;
  logic                shift_op;
  logic                itype_alu;
  logic [ALUC_W-1:0]   alu_sel;

  mc_cu_decode u_decode (
    .op    (op),
    .func  (func),
    .inst  (inst),
    .legal (legal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // ALU function for register and immediate arithmetic in EXE
  always_comb begin
    shift_op  = inst.i_sll || inst.i_srl || inst.i_sra;
    itype_alu = inst.i_addi || inst.i_andi || inst.i_ori || inst.i_xori || inst.i_lui;
    if (inst.i_add || inst.i_addi)      alu_sel = ALUC_ADD;
    else if (inst.i_sub)                alu_sel = ALUC_SUB;
    else if (inst.i_and || inst.i_andi) alu_sel = ALUC_AND;
    else if (inst.i_or || inst.i_ori)   alu_sel = ALUC_OR;
    else if (inst.i_xor || inst.i_xori) alu_sel = ALUC_XOR;
    else if (inst.i_lui)                alu_sel = ALUC_LUI;
    else if (inst.i_sll)                alu_sel = ALUC_SLL;
    else if (inst.i_srl)                alu_sel = ALUC_SRL;
    else if (inst.i_sra)                alu_sel = ALUC_SRA;
    else                                alu_sel = ALUC_ADD;
  end

  always_comb begin
    state_d  = state_q;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    shift    = 1'b0;
    sext     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REG;
    aluc     = ALUC_ADD;
    pcsource = PCS_ALU;
    case (state_q)
      S_IF: begin
        alusrcb = SRCB_FOUR;
        wir     = mem_ready;
        wpc     = mem_ready;
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        // branch target computed here while the instruction is decoded
        alusrcb = SRCB_IMM4;
        sext    = 1'b1;
        if (inst.i_j || inst.i_jal) begin
          wpc      = 1'b1;
          pcsource = PCS_JUMP;
          wreg     = inst.i_jal;
          jal      = inst.i_jal;
          state_d  = S_IF;
        end else if (inst.i_jr) begin
          wpc      = 1'b1;
          pcsource = PCS_JR;
          state_d  = S_IF;
        end else if (legal) begin
          state_d = S_EXE;
        end else begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_IF;
`endif
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        if (inst.i_beq || inst.i_bne) begin
          aluc     = ALUC_SUB;
          pcsource = PCS_ALUOUT;
          wpc      = inst.i_beq ? z : !z;
          state_d  = S_IF;
        end else if (inst.i_lw || inst.i_sw) begin
          alusrcb = SRCB_IMM;
          sext    = 1'b1;
          state_d = S_MEM;
        end else if (itype_alu) begin
          alusrcb = SRCB_IMM;
          sext    = inst.i_addi;
          aluc    = alu_sel;
          state_d = S_WB;
        end else begin
          shift   = shift_op;
          aluc    = alu_sel;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (inst.i_sw) begin
          wmem = 1'b1;
          if (mem_ready) state_d = S_IF;
        end else if (mem_ready) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        wreg    = 1'b1;
        m2reg   = inst.i_lw;
        regrt   = itype_alu || inst.i_lw;
        state_d = S_IF;
      end
`ifdef MC_CU_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IF;
    endcase
    // reset kills any write in flight without waiting for a clock edge
    if (reset) begin
      wpc  = 1'b0;
      wir  = 1'b0;
      wmem = 1'b0;
      wreg = 1'b0;
    end
  end

`ifdef MC_CU_ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

  assign state = state_q;

endmodule
